i2c_init_seq: RTL and testbench

I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

---
 rtl/i2c_init_seq_pkg.sv | 34 +++
 rtl/i2c_init_seq_if.sv | 25 ++
 rtl/i2c_init_seq_strobe_gen.sv | 40 ++++
 rtl/i2c_init_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_init_seq_pkg.sv
// Shared definitions for the I2C register-init sequencer.
//   op_e    : table entry opcodes held in tbl_data[17:16]
//   state_e : sequencer state encoding
//   LEN_WR / LEN_RD : controller transfer lengths for register writes/reads
//   is_idle_state() : states in which the sequencer reports not-busy
package i2c_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_DELAY = 2'b10,
        OP_END   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DELAY  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_e;

    // Byte count handed to the controller: addr+reg+data for writes, addr+reg for reads.
    localparam logic [4:0] LEN_WR = 5'd3;
    localparam logic [4:0] LEN_RD = 5'd2;

    function automatic logic is_idle_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/i2c_init_seq_if.sv
// Request/response bundle between the init sequencer and the I2C byte controller.
//   master : sequencer side (drives strobe, enable, address and register fields)
//   slave  : controller side (drives reg_done, i2c_ack, reg_rddata)
interface i2c_init_seq_if;
    logic       i2c_strobe;
    logic       i2c_enable;
    logic [6:0] i2c_addr;
    logic       reg_rdwr;
    logic [7:0] reg_addr;
    logic [4:0] reg_len;
    logic [7:0] reg_wrdata;
    logic       reg_done;
    logic       i2c_ack;
    logic [7:0] reg_rddata;

    modport master (
        output i2c_strobe, i2c_enable, i2c_addr, reg_rdwr, reg_addr, reg_len, reg_wrdata,
        input  reg_done, i2c_ack, reg_rddata
    );

    modport slave (
        input  i2c_strobe, i2c_enable, i2c_addr, reg_rdwr, reg_addr, reg_len, reg_wrdata,
        output reg_done, i2c_ack, reg_rddata
    );
endinterface

// File: rtl/i2c_init_seq_strobe_gen.sv
// Free-running bit-phase tick generator.
//   clk, arst : clock and asynchronous active-high reset
//   strobe_o  : high for one clk every CLK_DIV clks (while counter == CLK_DIV-1)
module i2c_strobe_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic arst,
    output logic strobe_o
);
    localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          strobe_q;

    // Next count: wrap to zero after the last phase.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter and registered tick; the tick is high exactly while cnt_q == CNT_LAST.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= (cnt_d == CNT_LAST);
        end
    end

    assign strobe_o = strobe_q;
endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven I2C register initialisation sequencer.
// Walks a table of {op, a, d} entries from entry 0 after a start pulse, issuing
// register writes/reads to an I2C byte controller, inserting strobe-timed delays,
// retrying NACKed commands up to MAX_RETRY times, and stopping at END, at the last
// table entry, or in a sticky error state.
//   clk, arst          : clock, asynchronous active-high reset
//   start, dev_addr    : run request pulse, 7-bit I2C target address
//   tbl_addr, tbl_data : table read port (data valid one clk after address)
//   bus (master)       : controller request/response bundle
//   busy, done         : activity flag, one-clk completion pulse
//   error, err_idx     : sticky failure flag and failing entry
//   rd_data, rd_valid  : read result and its one-clk qualifier
module i2c_init_seq
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter int MAX_RETRY = 3,
    parameter int TBL_AW    = 6
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [6:0]        dev_addr,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [17:0]       tbl_data,
    i2c_init_seq_if.master    bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW-1:0] err_idx,
    output logic [7:0]        rd_data,
    output logic              rd_valid
);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TBL_AW-1:0] TBL_LAST  = '1;

    state_e            state_q,   state_d;
    logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
    logic [6:0]        i2c_addr_q, i2c_addr_d;
    logic              rdwr_q,    rdwr_d;
    logic [7:0]        raddr_q,   raddr_d;
    logic [4:0]        len_q,     len_d;
    logic [7:0]        wrdata_q,  wrdata_d;
    logic              enable_q,  enable_d;
    logic [RW-1:0]     retry_q,   retry_d;
    logic [15:0]       delay_q,   delay_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              error_q,   error_d;
    logic [TBL_AW-1:0] err_idx_q, err_idx_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              reg_done_prev_q;

    logic strobe_s;
    logic done_edge_s;
    op_e  op_s;

    i2c_strobe_gen #(.CLK_DIV(CLK_DIV)) u_strobe (
        .clk      (clk),
        .arst     (arst),
        .strobe_o (strobe_s)
    );

    assign op_s        = op_e'(tbl_data[17:16]);
    // A reg_done already high on WAIT entry is stale; only a rising edge completes.
    assign done_edge_s = bus.reg_done & ~reg_done_prev_q;

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        tbl_addr_d = tbl_addr_q;
        i2c_addr_d = i2c_addr_q;
        rdwr_d     = rdwr_q;
        raddr_d    = raddr_q;
        len_d      = len_q;
        wrdata_d   = wrdata_q;
        retry_d    = retry_q;
        delay_d    = delay_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    tbl_addr_d = '0;
                    error_d    = 1'b0;
                    err_idx_d  = '0;
                    state_d    = ST_FETCH;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (op_s)
                    OP_END: begin
                        state_d = ST_DONE;
                    end
                    OP_DELAY: begin
                        delay_d = tbl_data[15:0];
                        state_d = ST_DELAY;
                    end
                    default: begin
                        i2c_addr_d = dev_addr;
                        raddr_d    = tbl_data[15:8];
                        wrdata_d   = tbl_data[7:0];
                        rdwr_d     = tbl_data[16];
                        len_d      = tbl_data[16] ? LEN_RD : LEN_WR;
                        retry_d    = '0;
                        state_d    = ST_ISSUE;
                    end
                endcase
            end
            ST_ISSUE: begin
                // Enable covers exactly one strobe, then wait for completion.
                if (strobe_s) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (done_edge_s) begin
                    if (!bus.i2c_ack) begin
                        if (rdwr_q) begin
                            rd_data_d  = bus.reg_rddata;
                            rd_valid_d = 1'b1;
                        end else begin
                            rd_data_d = rd_data_q;
                        end
                        if (tbl_addr_q == TBL_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            tbl_addr_d = tbl_addr_q + TBL_AW'(1);
                            state_d    = ST_FETCH;
                        end
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RW'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        err_idx_d = tbl_addr_q;
                        error_d   = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DELAY: begin
                // A loaded count of 0 behaves like 1: leave on the first strobe.
                if (strobe_s) begin
                    if (delay_q <= 16'd1) begin
                        if (tbl_addr_q == TBL_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            tbl_addr_d = tbl_addr_q + TBL_AW'(1);
                            state_d    = ST_FETCH;
                        end
                    end else begin
                        delay_d = delay_q - 16'd1;
                    end
                end else begin
                    delay_d = delay_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enable_d = (state_d == ST_ISSUE);
        done_d   = (state_d == ST_DONE);
        busy_d   = ~is_idle_state(state_d);
    end

    // State and output registers; reset drops enable in the same clk.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q         <= ST_IDLE;
            tbl_addr_q      <= '0;
            i2c_addr_q      <= 7'd0;
            rdwr_q          <= 1'b0;
            raddr_q         <= 8'd0;
            len_q           <= 5'd0;
            wrdata_q        <= 8'd0;
            enable_q        <= 1'b0;
            retry_q         <= '0;
            delay_q         <= 16'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            err_idx_q       <= '0;
            rd_data_q       <= 8'd0;
            rd_valid_q      <= 1'b0;
            reg_done_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tbl_addr_q      <= tbl_addr_d;
            i2c_addr_q      <= i2c_addr_d;
            rdwr_q          <= rdwr_d;
            raddr_q         <= raddr_d;
            len_q           <= len_d;
            wrdata_q        <= wrdata_d;
            enable_q        <= enable_d;
            retry_q         <= retry_d;
            delay_q         <= delay_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            err_idx_q       <= err_idx_d;
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
            reg_done_prev_q <= bus.reg_done;
        end
    end

    assign tbl_addr       = tbl_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_idx        = err_idx_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign bus.i2c_strobe = strobe_s;
    assign bus.i2c_enable = enable_q;
    assign bus.i2c_addr   = i2c_addr_q;
    assign bus.reg_rdwr   = rdwr_q;
    assign bus.reg_addr   = raddr_q;
    assign bus.reg_len    = len_q;
    assign bus.reg_wrdata = wrdata_q;
endmodule

// File: tb/tb_i2c_init_seq.sv
module tb_i2c_init_seq;
    localparam int TBL_AW = 6;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              start = 1'b0;
    logic [6:0]        dev_addr = 7'h3A;
    logic [TBL_AW-1:0] tbl_addr;
    logic [17:0]       tbl_data = 18'd0;
    logic              busy, done, error, rd_valid;
    logic [TBL_AW-1:0] err_idx;
    logic [7:0]        rd_data;

    logic [17:0] tbl [0:63];

    i2c_init_seq_if bus ();

    i2c_init_seq #(.CLK_DIV(4), .MAX_RETRY(3), .TBL_AW(TBL_AW)) dut (
        .clk      (clk),
        .arst     (arst),
        .start    (start),
        .dev_addr (dev_addr),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_idx  (err_idx),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    // Synchronous table ROM: data one clk after address.
    always @(posedge clk) tbl_data <= tbl[tbl_addr];

    // Controller model: reg_done pulses a few clks after enable falls.
    logic       model_nack = 1'b0;
    logic [7:0] model_rd   = 8'h00;
    logic       m_en_prev;
    int         m_cnt;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_en_prev      <= 1'b0;
            m_cnt          <= 0;
            bus.reg_done   <= 1'b0;
            bus.i2c_ack    <= 1'b0;
            bus.reg_rddata <= 8'h00;
        end else begin
            m_en_prev    <= bus.i2c_enable;
            bus.reg_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                bus.i2c_ack    <= model_nack;
                bus.reg_rddata <= model_rd;
            end
            if (m_en_prev && !bus.i2c_enable) m_cnt <= 3;
            else if (m_cnt != 0) m_cnt <= m_cnt - 1;
        end
    end

    // Event monitor sampled on the falling edge.
    int n_en = 0, n_done = 0, n_rdv = 0, n_strb = 0;
    logic       mon_en_prev = 1'b0;
    logic [7:0] cap_addr = 8'h00, cap_wr = 8'h00;
    logic [4:0] cap_len = 5'd0;
    logic       cap_rdwr = 1'b0;
    logic [6:0] cap_dev = 7'd0;
    always @(negedge clk) begin
        mon_en_prev <= bus.i2c_enable;
        if (bus.i2c_enable && !mon_en_prev) begin
            n_en     <= n_en + 1;
            cap_addr <= bus.reg_addr;
            cap_wr   <= bus.reg_wrdata;
            cap_len  <= bus.reg_len;
            cap_rdwr <= bus.reg_rdwr;
            cap_dev  <= bus.i2c_addr;
        end
        if (done)           n_done <= n_done + 1;
        if (rd_valid)       n_rdv  <= n_rdv + 1;
        if (bus.i2c_strobe) n_strb <= n_strb + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); #1;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    // Run until a done pulse or error, bounded.
    task automatic run_to_end(input string tag, input int max_cyc, input int base_done);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if ((n_done != base_done) || error) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, {31'd0, hit}, 32'd1);
    endtask

    int b_en, b_done, b_rdv, b_strb, nstr;
    bit got;

    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = {2'b11, 16'h0000};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_enable",   {31'd0, bus.i2c_enable}, 32'd0);
        check("rst_strobe",   {31'd0, bus.i2c_strobe}, 32'd0);
        check("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
        check("rst_reg_len",  {27'd0, bus.reg_len}, 32'd0);
        check("rst_error",    {31'd0, error}, 32'd0);
        check("rst_rd_data",  {24'd0, rd_data}, 32'd0);
        #1 arst = 1'b0;
        repeat (2) @(negedge clk);

        // Single WRITE then END
        tbl[0] = {2'b00, 8'h10, 8'hA5};
        tbl[1] = {2'b11, 16'h0000};
        b_en = n_en; b_done = n_done;
        pulse_start();
        check("wr_busy", {31'd0, busy}, 32'd1);
        run_to_end("wr", 500, b_done);
        check("wr_enables", n_en - b_en, 32'd1);
        check("wr_done",    n_done - b_done, 32'd1);
        check("wr_addr",    {24'd0, cap_addr}, 32'h10);
        check("wr_data",    {24'd0, cap_wr}, 32'hA5);
        check("wr_len",     {27'd0, cap_len}, 32'd3);
        check("wr_rdwr",    {31'd0, cap_rdwr}, 32'd0);
        check("wr_dev",     {25'd0, cap_dev}, 32'h3A);
        check("wr_error",   {31'd0, error}, 32'd0);
        @(negedge clk); #1;
        check("wr_idle_busy", {31'd0, busy}, 32'd0);

        // READ then END
        tbl[0] = {2'b01, 8'h20, 8'h00};
        model_rd = 8'h5C;
        b_en = n_en; b_done = n_done; b_rdv = n_rdv;
        pulse_start();
        run_to_end("rd", 500, b_done);
        check("rd_valid_cnt", n_rdv - b_rdv, 32'd1);
        check("rd_data",      {24'd0, rd_data}, 32'h5C);
        check("rd_rdwr",      {31'd0, cap_rdwr}, 32'd1);
        check("rd_len",       {27'd0, cap_len}, 32'd2);
        check("rd_addr",      {24'd0, cap_addr}, 32'h20);
        check("rd_enables",   n_en - b_en, 32'd1);

        // Permanent NACK: 1 + 3 retries then error
        tbl[0] = {2'b00, 8'h33, 8'h44};
        model_nack = 1'b1;
        b_en = n_en; b_done = n_done;
        pulse_start();
        run_to_end("nack", 1000, b_done);
        repeat (30) @(negedge clk);
        #1;
        check("nack_enables", n_en - b_en, 32'd4);
        check("nack_error",   {31'd0, error}, 32'd1);
        check("nack_err_idx", {26'd0, err_idx}, 32'd0);
        check("nack_done",    n_done - b_done, 32'd0);
        check("nack_busy",    {31'd0, busy}, 32'd0);
        model_nack = 1'b0;

        // DELAY 5 strobes then END; restart also clears error
        tbl[0] = {2'b10, 16'h0005};
        b_en = n_en; b_done = n_done;
        @(negedge clk); #1;
        b_strb = n_strb;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check("dly_err_clr", {31'd0, error}, 32'd0);
        run_to_end("dly", 200, b_done);
        nstr = n_strb - b_strb;
        check("dly_strobes_range", {31'd0, (nstr >= 5) && (nstr <= 7)}, 32'd1);
        check("dly_enables", n_en - b_en, 32'd0);
        check("dly_done",    n_done - b_done, 32'd1);

        // Reset while waiting for reg_done
        tbl[0] = {2'b00, 8'h55, 8'h66};
        b_en = n_en;
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if ((n_en != b_en) && !bus.i2c_enable) begin
                got = 1'b1;
                break;
            end
        end
        check("mid_reach_wait", {31'd0, got}, 32'd1);
        arst = 1'b1;
        @(negedge clk);
        check("mid_enable",   {31'd0, bus.i2c_enable}, 32'd0);
        check("mid_busy",     {31'd0, busy}, 32'd0);
        check("mid_reg_addr", {24'd0, bus.reg_addr}, 32'd0);
        check("mid_reg_len",  {27'd0, bus.reg_len}, 32'd0);
        check("mid_tbl_addr", {26'd0, tbl_addr}, 32'd0);
        check("mid_strobe",   {31'd0, bus.i2c_strobe}, 32'd0);
        #1 arst = 1'b0;
        b_en = n_en; b_done = n_done;
        pulse_start();
        run_to_end("mid_restart", 500, b_done);
        check("mid_restart_done", n_done - b_done, 32'd1);
        check("mid_restart_en",   n_en - b_en, 32'd1);
        check("mid_restart_err",  {31'd0, error}, 32'd0);

        // 64 WRITEs, no END: stops at the last entry
        for (int i = 0; i < 64; i++) tbl[i] = {2'b00, 2'b00, 6'(i), 8'(8'hFF - i)};
        b_en = n_en; b_done = n_done;
        pulse_start();
        run_to_end("full", 4000, b_done);
        check("full_enables",  n_en - b_en, 32'd64);
        check("full_done",     n_done - b_done, 32'd1);
        check("full_tbl_addr", {26'd0, tbl_addr}, 32'd63);
        check("full_last_wr",  {24'd0, cap_wr}, 32'hC0);
        check("full_error",    {31'd0, error}, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("full_no_wrap", {26'd0, tbl_addr}, 32'd63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
